// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection controller:
// state encoding, one-hot lamp codes and the per-state phase duration lookup.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    AR_TO_EW = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    AR_TO_NS = 3'd5,
    PED      = 3'd6,
    FLASH    = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // FLASH loads 0 so its countdown display reads blank/zero.
  function automatic int unsigned dur_of(input state_e      st,
                                         input int unsigned green_t,
                                         input int unsigned yellow_t,
                                         input int unsigned allred_t,
                                         input int unsigned ped_t);
    int unsigned d;
    case (st)
      NS_G, EW_G:         d = green_t;
      NS_Y, EW_Y:         d = yellow_t;
      AR_TO_EW, AR_TO_NS: d = allred_t;
      PED:                d = ped_t;
      FLASH:              d = 32'd0;
      default:            d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase countdown: loads on phase entry, decrements on each tick, and flags
// expiry when a tick arrives with one tick left.
module phase_timer #(
  parameter int CNT_W   = 6,
  parameter int RST_VAL = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_p,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins, zero holds (FLASH) instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      count_q <= CNT_W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == CNT_ONE);

endmodule

// File: rtl/traffic_xing_ctrl.sv
// Two-road intersection controller with pedestrian walk phase and night
// flashing mode; all lamp/debug outputs are registered alongside the state.
module traffic_xing_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_p,
  input  logic             tick_1s,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic [CNT_W-1:0] time_left,
  output logic [2:0]       phase
);

  localparam int DUR_MAX = 2 ** CNT_W;

  if (GREEN_T < 1 || GREEN_T >= DUR_MAX || YELLOW_T < 1 || YELLOW_T >= DUR_MAX ||
      ALLRED_T < 1 || ALLRED_T >= DUR_MAX || PED_T < 1 || PED_T >= DUR_MAX) begin : g_bad_dur
    $error("traffic_xing_ctrl: every phase duration must be >=1 and < 2**CNT_W");
  end

  state_e     state_q, state_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       ped_pending_q, ped_pending_d;
  logic       flash_ph_q, flash_ph_d;
  logic       load_s, expire_s;
  logic [CNT_W-1:0] load_val_s, count_s;

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_T)) u_timer (
    .sys_clk    (sys_clk),
    .sys_rst_p  (sys_rst_p),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .tick_i     (tick_1s),
    .count_o    (count_s),
    .expire_o   (expire_s)
  );

  // Next state, pedestrian latch, flash phase and registered-output values.
  always_comb begin
    state_d       = state_q;
    ped_pending_d = ped_pending_q | ped_req;
    flash_ph_d    = flash_ph_q;
    ns_d          = LAMP_R;
    ew_d          = LAMP_R;
    walk_d        = 1'b0;
    case (state_q)
      NS_G:     if (expire_s) state_d = NS_Y;     else state_d = state_q;
      NS_Y:     if (expire_s) state_d = AR_TO_EW; else state_d = state_q;
      EW_G:     if (expire_s) state_d = EW_Y;     else state_d = state_q;
      EW_Y:     if (expire_s) state_d = AR_TO_NS; else state_d = state_q;
      AR_TO_EW: begin
        if (expire_s) state_d = night_mode ? FLASH : EW_G;
        else          state_d = state_q;
      end
      // Night mode outranks a pending walk request at the NS clearance exit.
      AR_TO_NS: begin
        if (expire_s) begin
          if (night_mode)         state_d = FLASH;
          else if (ped_pending_q) state_d = PED;
          else                    state_d = NS_G;
        end else begin
          state_d = state_q;
        end
      end
      PED: begin
        ped_pending_d = ped_pending_q;
        if (expire_s) state_d = NS_G; else state_d = state_q;
      end
      FLASH: begin
        if (tick_1s && !night_mode) begin
          state_d    = AR_TO_NS;
          flash_ph_d = 1'b0;
        end else if (tick_1s) begin
          flash_ph_d = ~flash_ph_q;
        end else begin
          flash_ph_d = flash_ph_q;
        end
      end
      default: state_d = AR_TO_NS;
    endcase

    if ((state_d != state_q) && (state_d == PED || state_d == FLASH)) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_d;
    end

    case (state_d)
      NS_G:    ns_d = LAMP_G;
      NS_Y:    ns_d = LAMP_Y;
      EW_G:    ew_d = LAMP_G;
      EW_Y:    ew_d = LAMP_Y;
      PED:     walk_d = 1'b1;
      FLASH: begin
        ns_d = flash_ph_d ? LAMP_Y : LAMP_OFF;
        ew_d = flash_ph_d ? LAMP_Y : LAMP_OFF;
      end
      default: begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
      end
    endcase
  end

  assign load_s     = (state_d != state_q);
  assign load_val_s = CNT_W'(dur_of(state_d, GREEN_T, YELLOW_T, ALLRED_T, PED_T));

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      state_q       <= AR_TO_NS;
      ns_q          <= LAMP_R;
      ew_q          <= LAMP_R;
      walk_q        <= 1'b0;
      ped_pending_q <= 1'b0;
      flash_ph_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
      ped_pending_q <= ped_pending_d;
      flash_ph_q    <= flash_ph_d;
    end
  end

  assign ns_light  = ns_q;
  assign ew_light  = ew_q;
  assign ped_walk  = walk_q;
  assign time_left = count_s;
  assign phase     = state_q;

endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Directed bench for traffic_xing_ctrl: steps tick by tick through the normal
// cycle, walk requests, night flashing and asynchronous reset.
module tb_traffic_xing_ctrl;
  import traffic_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_p;
  logic       tick_1s = 1'b0;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] ns_light, ew_light, phase;
  logic       ped_walk;
  logic [3:0] time_left;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int tcnt     = 0;

  traffic_xing_ctrl #(
    .CNT_W(4), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1), .PED_T(3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_p  (sys_rst_p),
    .tick_1s    (tick_1s),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ped_walk   (ped_walk),
    .time_left  (time_left),
    .phase      (phase)
  );

  always #5 sys_clk = ~sys_clk;

  // One-cycle tick every 5 clocks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      tcnt    = (tcnt == 4) ? 0 : tcnt + 1;
      tick_1s = (tcnt == 4);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @tick%0d: got %0h expected %0h", tag, tick_no, obs, exp);
    end
  endtask

  function automatic logic [5:0] lamps_of(input state_e st, input bit fl);
    case (st)
      NS_G:    return {3'b001, 3'b100};
      NS_Y:    return {3'b010, 3'b100};
      EW_G:    return {3'b100, 3'b001};
      EW_Y:    return {3'b100, 3'b010};
      FLASH:   return fl ? {3'b010, 3'b010} : {3'b000, 3'b000};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Safety: both directions never non-red outside FLASH.
  always @(negedge sys_clk) begin
    chk_eq("safety", {31'd0, (ns_light != 3'b100) && (ew_light != 3'b100) && (phase != 3'd7)}, 32'd0);
  end

  task automatic step_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge sys_clk);
      seen = tick_1s;
    end
    #1;
    tick_no++;
    if (!seen) chk_eq("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic exp_now(input state_e st, input int tl, input bit fl);
    chk_eq("phase", {29'd0, phase}, {29'd0, st});
    chk_eq("time_left", {28'd0, time_left}, tl);
    chk_eq("lamps", {26'd0, ns_light, ew_light}, {26'd0, lamps_of(st, fl)});
    chk_eq("walk", {31'd0, ped_walk}, {31'd0, st == PED});
  endtask

  task automatic exp_tick(input state_e st, input int tl, input bit fl);
    step_tick();
    exp_now(st, tl, fl);
  endtask

  task automatic exp_range(input state_e st, input int from, input int to);
    for (int t = from; t >= to; t--) exp_tick(st, t, 1'b0);
  endtask

  // From NS_G with 4 left, through to the AR_TO_NS clearance.
  task automatic exp_to_arns();
    exp_range(NS_G, 3, 1);
    exp_range(NS_Y, 2, 1);
    exp_range(AR_TO_EW, 1, 1);
    exp_range(EW_G, 4, 1);
    exp_range(EW_Y, 2, 1);
    exp_range(AR_TO_NS, 1, 1);
  endtask

  task automatic pulse_ped();
    @(negedge sys_clk); ped_req = 1'b1;
    @(negedge sys_clk); ped_req = 1'b0;
    #1;
  endtask

  initial begin
    sys_rst_p  = 1'b1;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    exp_now(AR_TO_NS, 1, 1'b0);
    chk_eq("rst_ped_pending", {31'd0, dut.ped_pending_q}, 32'd0);
    chk_eq("rst_flash_ph", {31'd0, dut.flash_ph_q}, 32'd0);
    @(negedge sys_clk);
    sys_rst_p = 1'b0;

    // 1: plain cycle, 14 ticks per period
    exp_range(NS_G, 4, 4);
    exp_to_arns();
    exp_range(NS_G, 4, 4);

    // 2: one-cycle walk request in EW_G, served once
    exp_range(NS_G, 3, 1);
    exp_range(NS_Y, 2, 1);
    exp_range(AR_TO_EW, 1, 1);
    exp_range(EW_G, 4, 4);
    pulse_ped();
    chk_eq("ped_latched", {31'd0, dut.ped_pending_q}, 32'd1);
    exp_range(EW_G, 3, 1);
    exp_range(EW_Y, 2, 1);
    exp_range(AR_TO_NS, 1, 1);
    exp_range(PED, 3, 1);
    exp_range(NS_G, 4, 4);
    exp_to_arns();
    exp_range(NS_G, 4, 4);

    // 3: request held through PED entry, clear wins
    @(negedge sys_clk); ped_req = 1'b1;
    exp_to_arns();
    exp_range(PED, 3, 3);
    chk_eq("ped_clr_on_entry", {31'd0, dut.ped_pending_q}, 32'd0);
    @(negedge sys_clk); ped_req = 1'b0;
    exp_range(PED, 2, 1);
    exp_range(NS_G, 4, 4);
    exp_to_arns();
    exp_range(NS_G, 4, 4);

    // 4: night mode raised in NS_G, flashing, then back via AR_TO_NS
    @(negedge sys_clk); night_mode = 1'b1;
    exp_range(NS_G, 3, 1);
    exp_range(NS_Y, 2, 1);
    exp_range(AR_TO_EW, 1, 1);
    exp_tick(FLASH, 0, 1'b0);
    exp_tick(FLASH, 0, 1'b1);
    exp_tick(FLASH, 0, 1'b0);
    exp_tick(FLASH, 0, 1'b1);
    @(negedge sys_clk); night_mode = 1'b0;
    exp_range(AR_TO_NS, 1, 1);
    exp_range(NS_G, 4, 4);

    // 5: night outranks pending walk at AR_TO_NS exit
    pulse_ped();
    chk_eq("ped_latched2", {31'd0, dut.ped_pending_q}, 32'd1);
    exp_range(NS_G, 3, 1);
    exp_range(NS_Y, 2, 1);
    exp_range(AR_TO_EW, 1, 1);
    exp_range(EW_G, 4, 4);
    @(negedge sys_clk); night_mode = 1'b1;
    exp_range(EW_G, 3, 1);
    exp_range(EW_Y, 2, 1);
    exp_range(AR_TO_NS, 1, 1);
    exp_tick(FLASH, 0, 1'b0);
    chk_eq("ped_clr_on_flash", {31'd0, dut.ped_pending_q}, 32'd0);
    @(negedge sys_clk); night_mode = 1'b0;
    exp_range(AR_TO_NS, 1, 1);
    exp_range(NS_G, 4, 4);

    // 6: asynchronous reset in the middle of EW_Y
    exp_range(NS_G, 3, 1);
    exp_range(NS_Y, 2, 1);
    exp_range(AR_TO_EW, 1, 1);
    exp_range(EW_G, 4, 1);
    exp_range(EW_Y, 2, 2);
    @(negedge sys_clk);
    #2 sys_rst_p = 1'b1;
    #1;
    exp_now(AR_TO_NS, 1, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst_p = 1'b0;
    exp_range(NS_G, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
